// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU arbiter slice: ALU funct3 codes,
// the packed ALU control bundle and requester-id width helpers.
package alu_pkg;

  localparam logic [2:0] F3_ADD_SUB = 3'd0;
  localparam logic [2:0] F3_SLL     = 3'd1;
  localparam logic [2:0] F3_SLT     = 3'd2;
  localparam logic [2:0] F3_SLTU    = 3'd3;
  localparam logic [2:0] F3_XOR     = 3'd4;
  localparam logic [2:0] F3_SR      = 3'd5;
  localparam logic [2:0] F3_OR      = 3'd6;
  localparam logic [2:0] F3_AND     = 3'd7;

  typedef struct packed {
    logic       insn30;
    logic [2:0] funct3;
    logic       w;
  } alu_op_t;

  localparam int unsigned NREQ_DEFAULT = 2;
  localparam int unsigned REQ_ID_W     = $clog2(NREQ_DEFAULT);

  // Requester id width for an arbitrary NREQ; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: scans the request vector upward from ptr (mod NREQ)
// and returns the first requester found as a one-hot grant plus its index.
module rr_pick
  import alu_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEFAULT,
  parameter int unsigned IDW  = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  winner,
  output logic            any
);

  // First valid requester at or after ptr, wrapping at NREQ.
  always_comb begin
    int unsigned idx;
    idx    = 0;
    grant  = '0;
    winner = '0;
    any    = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        winner     = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one combinational ALU between NREQ requesters: round-robin grant,
// registered ALU operands (stage N+1), registered per-requester response (N+2).
// Optional build macro ALU_ARB_FWD_EN adds per-requester operand forwarding
// of each requester's own most recent result.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREQ = NREQ_DEFAULT,
  parameter int unsigned TAGW = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_insn30,
  input  logic [3*NREQ-1:0]    req_funct3,
  input  logic [NREQ-1:0]      req_w,
  input  logic [XLEN*NREQ-1:0] req_op1,
  input  logic [XLEN*NREQ-1:0] req_op2,
  input  logic [TAGW*NREQ-1:0] req_rd,
`ifdef ALU_ARB_FWD_EN
  input  logic [NREQ-1:0]      req_fwd1,
  input  logic [NREQ-1:0]      req_fwd2,
`endif
  output logic                 alu_insn30,
  output logic [2:0]           alu_funct3,
  output logic                 alu_w,
  output logic [XLEN-1:0]      alu_op1,
  output logic [XLEN-1:0]      alu_op2,
  input  logic [XLEN-1:0]      alu_result,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [TAGW-1:0]      rsp_rd,
  output logic [XLEN-1:0]      rsp_data
);

  localparam int unsigned IDW = id_width(NREQ);

  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  winner;
  logic [NREQ-1:0] grant;
  logic            any;
  logic            issue;

  logic            stg_valid;
  logic [IDW-1:0]  stg_owner;
  logic [TAGW-1:0] stg_rd;

  alu_op_t         sel_op;
  logic [XLEN-1:0] sel_op1;
  logic [XLEN-1:0] sel_op2;
  logic [TAGW-1:0] sel_rd;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req    (req_valid),
    .ptr    (ptr),
    .grant  (grant),
    .winner (winner),
    .any    (any)
  );

`ifdef ALU_ARB_FWD_EN
  logic [XLEN-1:0] last_result [NREQ];
  logic [XLEN-1:0] fwd_src;
`endif

  // Grant is suppressed while reset is held so nothing is issued or acknowledged.
  always_comb begin
    issue     = any & ~reset;
    req_ready = issue ? grant : '0;
  end

  // Steer the winner's fields (optionally with forwarded operands) to the ALU stage.
  always_comb begin
    sel_op.insn30 = req_insn30[winner];
    sel_op.funct3 = req_funct3[32'(winner)*3 +: 3];
    sel_op.w      = req_w[winner];
    sel_op1       = req_op1[32'(winner)*XLEN +: XLEN];
    sel_op2       = req_op2[32'(winner)*XLEN +: XLEN];
    sel_rd        = req_rd[32'(winner)*TAGW +: TAGW];
`ifdef ALU_ARB_FWD_EN
    // Previous op still in the ALU stage: take the live result; otherwise the stored one.
    fwd_src = (stg_valid && (stg_owner == winner)) ? alu_result : last_result[winner];
    if (req_fwd1[winner]) sel_op1 = fwd_src;
    if (req_fwd2[winner]) sel_op2 = fwd_src;
`endif
  end

  // Round-robin pointer: advance past the winner on every grant.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= '0;
    end else if (issue) begin
      ptr <= (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
    end
  end

  // ALU stage: capture the granted op; operands hold when idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      stg_valid  <= 1'b0;
      stg_owner  <= '0;
      stg_rd     <= '0;
      alu_insn30 <= 1'b0;
      alu_funct3 <= '0;
      alu_w      <= 1'b0;
      alu_op1    <= '0;
      alu_op2    <= '0;
    end else begin
      stg_valid <= issue;
      if (issue) begin
        stg_owner  <= winner;
        stg_rd     <= sel_rd;
        alu_insn30 <= sel_op.insn30;
        alu_funct3 <= sel_op.funct3;
        alu_w      <= sel_op.w;
        alu_op1    <= sel_op1;
        alu_op2    <= sel_op2;
      end
    end
  end

  // Response stage: return the ALU result and tag to the stage owner.
  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_valid <= '0;
      rsp_rd    <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= '0;
      if (stg_valid) begin
        rsp_valid[stg_owner] <= 1'b1;
        rsp_rd               <= stg_rd;
        rsp_data             <= alu_result;
      end
    end
  end

`ifdef ALU_ARB_FWD_EN
  // Per-requester last result, written on the same edge that loads its response.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREQ; i++) last_result[i] <= '0;
    end else if (stg_valid) begin
      last_result[stg_owner] <= alu_result;
    end
  end
`endif

endmodule
